// File: rtl/game_pkg.sv
// Shared mode encodings, default geometry/physics constants and small helpers for the runner
// game core.
`timescale 1ns/1ps
package game_pkg;

    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_PLAY  = 2'b01;
    localparam logic [1:0] MODE_PAUSE = 2'b10;
    localparam logic [1:0] MODE_OVER  = 2'b11;

    localparam int unsigned DEF_NUM_OBS     = 10;
    localparam int unsigned DEF_X_W         = 10;
    localparam int unsigned DEF_Y_W         = 9;
    localparam int unsigned DEF_PLAYER_X    = 160;
    localparam int unsigned DEF_PLAYER_SIZE = 40;
    localparam int unsigned DEF_OBS_SIZE    = 40;
    localparam int unsigned DEF_UPPER_BOUND = 20;
    localparam int unsigned DEF_LOWER_BOUND = 460;
    localparam int unsigned DEF_MAX_VEL     = 8;
    localparam int unsigned DEF_ACCEL       = 1;
    localparam int unsigned DEF_LIVES       = 3;
    localparam int unsigned DEF_INVULN_FR   = 60;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/game_if.sv
// Frame-level bus between obstacle generator, game core and renderer.
`timescale 1ns/1ps
interface game_if #(
    parameter int unsigned NUM_OBS = 10,
    parameter int unsigned X_W     = 10,
    parameter int unsigned Y_W     = 9
);
    logic                     frame_tick;
    logic                     start;
    logic                     pause;
    logic                     flap;
    logic [NUM_OBS*X_W-1:0]   obs_x;
    logic [NUM_OBS*Y_W-1:0]   obs_y;
    logic [NUM_OBS-1:0]       obs_valid;
    logic [1:0]               gamemode;
    logic [Y_W-1:0]           player_y;
    logic [2:0]               lives;
    logic [15:0]              score;
    logic                     hit;

    modport master (
        output frame_tick, start, pause, flap, obs_x, obs_y, obs_valid,
        input  gamemode, player_y, lives, score, hit
    );

    modport slave (
        input  frame_tick, start, pause, flap, obs_x, obs_y, obs_valid,
        output gamemode, player_y, lives, score, hit
    );
endinterface

// File: rtl/game_collide.sv
// Combinational player-vs-obstacle overlap test across all slots, OR-reduced to one flag.
`timescale 1ns/1ps
module game_collide #(
    parameter int unsigned NUM_OBS     = 10,
    parameter int unsigned X_W         = 10,
    parameter int unsigned Y_W         = 9,
    parameter int unsigned PLAYER_X    = 160,
    parameter int unsigned PLAYER_SIZE = 40,
    parameter int unsigned OBS_SIZE    = 40
) (
    input  logic [Y_W-1:0]         player_y_i,
    input  logic [NUM_OBS*X_W-1:0] obs_x_i,
    input  logic [NUM_OBS*Y_W-1:0] obs_y_i,
    input  logic [NUM_OBS-1:0]     obs_valid_i,
    output logic                   any_hit_o
);

    localparam logic [X_W:0] PX_L  = (X_W+1)'(PLAYER_X);
    localparam logic [X_W:0] PX_R  = (X_W+1)'(PLAYER_X + PLAYER_SIZE);
    localparam logic [X_W:0] OS_X  = (X_W+1)'(OBS_SIZE);
    localparam logic [Y_W:0] OS_Y  = (Y_W+1)'(OBS_SIZE);
    localparam logic [Y_W:0] PS_Y  = (Y_W+1)'(PLAYER_SIZE);

    logic [NUM_OBS-1:0] overlap;
    logic [Y_W:0]       py_top;
    logic [Y_W:0]       py_bot;

    assign py_top = {1'b0, player_y_i};
    assign py_bot = py_top + PS_Y;

    // Strict inequalities: edge contact does not count as overlap.
    for (genvar k = 0; k < NUM_OBS; k++) begin : g_slot
        logic [X_W:0] ox;
        logic [Y_W:0] oy;
        assign ox = {1'b0, obs_x_i[k*X_W +: X_W]};
        assign oy = {1'b0, obs_y_i[k*Y_W +: Y_W]};
        assign overlap[k] = obs_valid_i[k]
                            && (PX_L < ox + OS_X) && (PX_R > ox)
                            && (py_top < oy + OS_Y) && (py_bot > oy);
    end

    assign any_hit_o = |overlap;

endmodule

// File: rtl/game_core_n.sv
// Runner game core: mode FSM, player vertical physics, lives with post-hit invulnerability and
// frame score. State advances only on frame_tick while playing.
`timescale 1ns/1ps
module game_core_n
    import game_pkg::*;
#(
    parameter int unsigned NUM_OBS     = DEF_NUM_OBS,
    parameter int unsigned X_W         = DEF_X_W,
    parameter int unsigned Y_W         = DEF_Y_W,
    parameter int unsigned PLAYER_X    = DEF_PLAYER_X,
    parameter int unsigned PLAYER_SIZE = DEF_PLAYER_SIZE,
    parameter int unsigned OBS_SIZE    = DEF_OBS_SIZE,
    parameter int unsigned UPPER_BOUND = DEF_UPPER_BOUND,
    parameter int unsigned LOWER_BOUND = DEF_LOWER_BOUND,
    parameter int unsigned MAX_VEL     = DEF_MAX_VEL,
    parameter int unsigned ACCEL       = DEF_ACCEL,
    parameter int unsigned LIVES       = DEF_LIVES,
    parameter int unsigned INVULN_FR   = DEF_INVULN_FR
) (
    input logic   clk,
    input logic   rst,
    game_if.slave bus
);

    localparam int unsigned IW = (INVULN_FR > 0) ? $clog2(INVULN_FR + 1) : 1;

    localparam logic [Y_W-1:0] Y_INIT  = Y_W'((LOWER_BOUND - UPPER_BOUND) / 2);
    localparam logic [Y_W-1:0] Y_MIN   = Y_W'(UPPER_BOUND);
    localparam logic [Y_W-1:0] Y_MAX   = Y_W'(LOWER_BOUND - PLAYER_SIZE);
    localparam logic [Y_W-1:0] V_MAX   = Y_W'(MAX_VEL);
    localparam logic [Y_W-1:0] V_ACC   = Y_W'(ACCEL);
    localparam logic [2:0]     L_INIT  = 3'(LIVES);
    localparam logic [IW-1:0]  INV_SET = IW'(INVULN_FR);

    logic [1:0]     mode_q,   mode_d;
    logic [Y_W-1:0] y_q,      y_d;
    logic [Y_W-1:0] vel_q,    vel_d;
    logic           dir_q,    dir_d;
    logic [2:0]     lives_q,  lives_d;
    logic [15:0]    score_q,  score_d;
    logic [IW-1:0]  invuln_q, invuln_d;
    logic           hit_q,    hit_d;

    logic                  any_hit;
    logic                  want_down;
    logic [Y_W-1:0]        vel_n;
    logic                  dir_n;
    logic signed [Y_W+1:0] y_sum;
    logic [Y_W-1:0]        y_n;
    logic [IW-1:0]         invuln_dec;
    logic                  take_hit;

    game_collide #(
        .NUM_OBS     (NUM_OBS),
        .X_W         (X_W),
        .Y_W         (Y_W),
        .PLAYER_X    (PLAYER_X),
        .PLAYER_SIZE (PLAYER_SIZE),
        .OBS_SIZE    (OBS_SIZE)
    ) u_collide (
        .player_y_i  (y_q),
        .obs_x_i     (bus.obs_x),
        .obs_y_i     (bus.obs_y),
        .obs_valid_i (bus.obs_valid),
        .any_hit_o   (any_hit)
    );

    // Candidate physics step; only committed on a PLAY tick. dir 1 = moving down (+y).
    always_comb begin
        want_down = ~bus.flap;
        vel_n     = vel_q;
        dir_n     = dir_q;
        if (want_down == dir_q) begin
            vel_n = (vel_q + V_ACC > V_MAX) ? V_MAX : vel_q + V_ACC;
        end else if (vel_q >= V_ACC) begin
            vel_n = vel_q - V_ACC;
        end else begin
            vel_n = V_ACC - vel_q;
            dir_n = want_down;
        end

        if (dir_n) begin
            y_sum = $signed({2'b00, y_q}) + $signed({2'b00, vel_n});
        end else begin
            y_sum = $signed({2'b00, y_q}) - $signed({2'b00, vel_n});
        end

        if (y_sum < $signed({2'b00, Y_MIN})) begin
            y_n = Y_MIN;
        end else if (y_sum > $signed({2'b00, Y_MAX})) begin
            y_n = Y_MAX;
        end else begin
            y_n = y_sum[Y_W-1:0];
        end
    end

    // Immunity is judged after this tick's decrement, so a hit on tick T re-arms on T+INVULN_FR.
    assign invuln_dec = (invuln_q != '0) ? invuln_q - IW'(1) : '0;
    assign take_hit   = any_hit && (invuln_dec == '0);

    always_comb begin
        mode_d   = mode_q;
        y_d      = y_q;
        vel_d    = vel_q;
        dir_d    = dir_q;
        lives_d  = lives_q;
        score_d  = score_q;
        invuln_d = invuln_q;
        hit_d    = 1'b0;

        if (!bus.start) begin
            mode_d   = MODE_IDLE;
            y_d      = Y_INIT;
            vel_d    = '0;
            dir_d    = 1'b0;
            lives_d  = L_INIT;
            score_d  = '0;
            invuln_d = '0;
        end else begin
            case (mode_q)
                MODE_IDLE: mode_d = MODE_PLAY;
                MODE_PLAY: begin
                    if (bus.pause) begin
                        mode_d = MODE_PAUSE;
                    end
                    if (bus.frame_tick) begin
                        y_d      = y_n;
                        vel_d    = vel_n;
                        dir_d    = dir_n;
                        score_d  = sat_inc16(score_q);
                        invuln_d = invuln_dec;
                        if (take_hit) begin
                            hit_d    = 1'b1;
                            invuln_d = INV_SET;
                            lives_d  = lives_q - 3'd1;
                            if (lives_q == 3'd1) begin
                                mode_d = MODE_OVER;
                            end
                        end
                    end
                end
                MODE_PAUSE: begin
                    if (!bus.pause) begin
                        mode_d = MODE_PLAY;
                    end
                end
                MODE_OVER: mode_d = MODE_OVER;
                default:   mode_d = MODE_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= MODE_IDLE;
            y_q      <= Y_INIT;
            vel_q    <= '0;
            dir_q    <= 1'b0;
            lives_q  <= L_INIT;
            score_q  <= '0;
            invuln_q <= '0;
            hit_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            y_q      <= y_d;
            vel_q    <= vel_d;
            dir_q    <= dir_d;
            lives_q  <= lives_d;
            score_q  <= score_d;
            invuln_q <= invuln_d;
            hit_q    <= hit_d;
        end
    end

    assign bus.gamemode = mode_q;
    assign bus.player_y = y_q;
    assign bus.lives    = lives_q;
    assign bus.score    = score_q;
    assign bus.hit      = hit_q;

endmodule
